fetch_unit: RTL and testbench

- Instruction-fetch front end: generates word addresses and read enables for the synchronous instruction ROM and captures its 1-cycle-latency data.
- Pairs each fetched word with its PC and presents {pc, inst, fault} to decode over a valid/ready handshake.
- Sits between the instruction ROM (downstream: address/enable in, registered inst out, inst forced 0 during reset, held when enable low) and decode.
- Handles sequential PC+4, redirects from execute, decode backpressure and wrong-path flush.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_if.sv | 14 +
 rtl/fetch_buf.sv | 82 ++++++++
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned IMEM_AW = 30;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            fault;
  } fetch_entry_t;

  // Sequential successor of a (possibly misaligned) fetch address; wraps at 2^32.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] addr);
    return (addr & ~XLEN'(3)) + XLEN'(4);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-to-decode valid/ready handshake carrying {pc, inst, fault}.
interface fetch_if;
  import fetch_pkg::*;

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] pc;
  logic [ILEN-1:0] inst;
  logic            fault;

  modport master (output valid, pc, inst, fault, input ready);
  modport slave  (input valid, pc, inst, fault, output ready);

endinterface

// File: rtl/fetch_buf.sv
// Circular FIFO of fetch entries with synchronous flush and a registered head.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_entry,
  input  logic                       pop,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t               head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  head_q, head_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      // Reading the post-write array gives push-into-empty bypass for free;
      // an empty buffer keeps presenting the last head.
      if (count_d != '0) begin
        head_d = mem_d[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign count = count_q;
  assign head  = head_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && !flush && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: drives the synchronous ROM, pairs returned words
// with their PC and buffers them for decode; handles redirect and backpressure.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_pc,
  input  logic [ILEN-1:0]    imem_inst,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  fetch_if.master            out
);

  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_fault_q, inflight_fault_d;

  logic [XLEN-1:0] fetch_addr;
  logic            issue;
  logic            push;
  logic            pop;
  logic [CW-1:0]   buf_count;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  // Credit counts buffered plus in-flight words only, so out_ready never
  // reaches the ROM enable path.
  always_comb begin
    fetch_addr = redirect_valid ? redirect_pc : pc_q;
    issue      = !rst && (redirect_valid ||
                          (32'(buf_count) + 32'(inflight_q)) < DEPTH);
    push       = inflight_q && !redirect_valid;
    push_entry = '{pc: inflight_pc_q, inst: imem_inst, fault: inflight_fault_q};
  end

  always_comb begin
    pc_d             = pc_q;
    inflight_d       = issue;
    inflight_pc_d    = inflight_pc_q;
    inflight_fault_d = inflight_fault_q;
    if (issue) begin
      inflight_pc_d    = fetch_addr;
      inflight_fault_d = redirect_valid && (redirect_pc[1:0] != 2'b00);
      pc_d             = next_seq_pc(fetch_addr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q             <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_fault_q <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_fault_q <= inflight_fault_d;
    end
  end

  fetch_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (buf_count),
    .head       (head)
  );

  assign imem_en   = issue;
  assign imem_pc   = fetch_addr[XLEN-1:2];
  assign out.valid = (buf_count != '0) && !redirect_valid;
  assign out.pc    = head.pc;
  assign out.inst  = head.inst;
  assign out.fault = head.fault;
  assign pop       = out.valid && out.ready;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// multi-cycle sequences and random stimulus against a transaction-level model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_en;
  logic [29:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  fetch_if dec_if();

  fetch_unit #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out            (dec_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [29:0] w);
    return 32'h1000_0000 + {2'b00, w};
  endfunction

  // Synchronous ROM: zero in reset, holds output while disabled.
  always @(posedge clk or posedge rst) begin
    if (rst)          imem_inst <= '0;
    else if (imem_en) imem_inst <= rom_word(imem_pc);
  end

  // Model: every issued request, oldest first, until popped or flushed.
  typedef struct {
    logic [31:0] pc;
    logic        fault;
    int unsigned cyc;
  } mentry_t;

  mentry_t     mq[$];
  logic [31:0] m_next_pc;
  int unsigned m_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    mq.delete();
    m_next_pc = RESET_PC;
  endtask

  task automatic drive(input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    rst            = 1'b0;
    redirect_valid = rv;
    redirect_pc    = rpc;
    dec_if.ready   = rdy;
    #1;
  endtask

  // Check this cycle against the model, then step the model across the edge.
  task automatic advance();
    logic        e_en;
    logic        e_valid;
    logic [31:0] addr;
    mentry_t     h;
    e_en    = redirect_valid || (mq.size() < DEPTH);
    addr    = redirect_valid ? redirect_pc : m_next_pc;
    e_valid = !redirect_valid && (mq.size() != 0) && (mq[0].cyc + 2 <= m_cyc);
    chk("imem_en", 32'(imem_en), 32'(e_en));
    if (e_en) chk("imem_pc", 32'(imem_pc), 32'(addr[31:2]));
    chk("out_valid", 32'(dec_if.valid), 32'(e_valid));
    if (e_valid) begin
      h = mq[0];
      chk("out_pc", dec_if.pc, h.pc);
      chk("out_inst", dec_if.inst, rom_word(h.pc[31:2]));
      chk("out_fault", 32'(dec_if.fault), 32'(h.fault));
    end
    if (redirect_valid) mq.delete();
    else if (e_valid && dec_if.ready) void'(mq.pop_front());
    if (e_en) begin
      mq.push_back('{pc: addr, fault: redirect_valid && (addr[1:0] != 2'b00), cyc: m_cyc});
      m_next_pc = (addr & ~32'd3) + 32'd4;
    end
    m_cyc++;
    @(posedge clk);
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        en;
    logic [29:0] ipc;
    logic        valid;
    logic        dchk;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } vec_t;

  localparam int NV = 13;
  vec_t vec[NV];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Startup flow, misaligned redirect, then redirect to the top word and wrap.
    vec[0]  = '{1'b0, 32'h0,         1'b1, 1'b1, 30'h0,        1'b0, 1'b1, 32'h0,         32'h0,         1'b0};
    vec[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 30'h1,        1'b0, 1'b0, 32'h0,         32'h0,         1'b0};
    vec[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 30'h2,        1'b1, 1'b1, 32'h0,         32'h1000_0000, 1'b0};
    vec[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 30'h3,        1'b1, 1'b1, 32'h4,         32'h1000_0001, 1'b0};
    vec[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 30'h4,        1'b1, 1'b1, 32'h8,         32'h1000_0002, 1'b0};
    vec[5]  = '{1'b1, 32'h42,        1'b1, 1'b1, 30'h10,       1'b0, 1'b0, 32'h0,         32'h0,         1'b0};
    vec[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 30'h11,       1'b0, 1'b0, 32'h0,         32'h0,         1'b0};
    vec[7]  = '{1'b0, 32'h0,         1'b1, 1'b1, 30'h12,       1'b1, 1'b1, 32'h42,        32'h1000_0010, 1'b1};
    vec[8]  = '{1'b0, 32'h0,         1'b1, 1'b1, 30'h13,       1'b1, 1'b1, 32'h44,        32'h1000_0011, 1'b0};
    vec[9]  = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 30'h3FFF_FFFF, 1'b0, 1'b0, 32'h0,        32'h0,         1'b0};
    vec[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 30'h0,        1'b0, 1'b0, 32'h0,         32'h0,         1'b0};
    vec[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 30'h1,        1'b1, 1'b1, 32'hFFFF_FFFC, 32'h4FFF_FFFF, 1'b0};
    vec[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 30'h2,        1'b1, 1'b1, 32'h0,         32'h1000_0000, 1'b0};

    redirect_valid = 1'b0;
    redirect_pc    = '0;
    dec_if.ready   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_imem_en", 32'(imem_en), 32'd0);
    chk("reset_out_valid", 32'(dec_if.valid), 32'd0);
    chk("reset_out_pc", dec_if.pc, 32'd0);

    for (int i = 0; i < NV; i++) begin
      drive(vec[i].rv, vec[i].rpc, vec[i].rdy);
      chk($sformatf("vec%0d_en", i), 32'(imem_en), 32'(vec[i].en));
      if (vec[i].en) chk($sformatf("vec%0d_ipc", i), 32'(imem_pc), 32'(vec[i].ipc));
      chk($sformatf("vec%0d_valid", i), 32'(dec_if.valid), 32'(vec[i].valid));
      if (vec[i].dchk) begin
        chk($sformatf("vec%0d_pc", i), dec_if.pc, vec[i].pc);
        chk($sformatf("vec%0d_inst", i), dec_if.inst, vec[i].inst);
        chk($sformatf("vec%0d_fault", i), 32'(dec_if.fault), 32'(vec[i].fault));
      end
      advance();
    end

    // Backpressure: buffer fills to DEPTH, ROM enable drops, head stays put.
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 1'b0);
      chk("bp_valid", 32'(dec_if.valid), 32'd1);
      chk("bp_pc_stable", dec_if.pc, 32'h4);
      chk("bp_inst_stable", dec_if.inst, 32'h1000_0001);
      chk("bp_en", 32'(imem_en), (i < 2) ? 32'd1 : 32'd0);
      advance();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      advance();
    end

    // Two buffered plus one in flight, then redirect to 0x40.
    drive(1'b1, 32'h100, 1'b0); advance();
    drive(1'b0, 32'h0, 1'b0);   advance();
    drive(1'b0, 32'h0, 1'b0);   advance();
    drive(1'b1, 32'h40, 1'b1);
    chk("redir_valid_low", 32'(dec_if.valid), 32'd0);
    advance();
    drive(1'b0, 32'h0, 1'b1);
    chk("redir_bubble", 32'(dec_if.valid), 32'd0);
    advance();
    drive(1'b0, 32'h0, 1'b1);
    chk("redir_first_valid", 32'(dec_if.valid), 32'd1);
    chk("redir_first_pc", dec_if.pc, 32'h40);
    chk("redir_first_inst", dec_if.inst, 32'h1000_0010);
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      advance();
    end

    // Async reset with three entries buffered.
    drive(1'b0, 32'h0, 1'b0); advance();
    drive(1'b0, 32'h0, 1'b0); advance();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(dec_if.valid), 32'd0);
    chk("arst_imem_en", 32'(imem_en), 32'd0);
    chk("arst_out_pc", dec_if.pc, 32'd0);
    chk("arst_out_inst", dec_if.inst, 32'd0);
    chk("arst_out_fault", 32'(dec_if.fault), 32'd0);
    repeat (2) @(posedge clk);
    model_reset();
    drive(1'b0, 32'h0, 1'b1);
    chk("post_rst_en", 32'(imem_en), 32'd1);
    chk("post_rst_ipc", 32'(imem_pc), 32'(RESET_PC[31:2]));
    advance();
    drive(1'b0, 32'h0, 1'b1); advance();
    drive(1'b0, 32'h0, 1'b1);
    chk("post_rst_valid", 32'(dec_if.valid), 32'd1);
    chk("post_rst_pc", dec_if.pc, RESET_PC);
    advance();

    // Random redirects (aligned and misaligned) and random backpressure.
    for (int i = 0; i < 600; i++) begin
      logic        rv;
      logic [31:0] rpc;
      logic        rdy;
      rv  = ($urandom_range(0, 11) == 0);
      rpc = $urandom;
      if ($urandom_range(0, 1) == 0) rpc[1:0] = 2'b00;
      rdy = ($urandom_range(0, 9) < 6);
      drive(rv, rpc, rdy);
      advance();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
